// File: rtl/ysyx_23060042_ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060042_ifu_fetch_if
// Description : Instruction-memory request/response bus, decode-side
//               instruction hand-off, and execute/decode control inputs
//               (redirect, halt) of the fetch unit.
//               The master modport is the fetch unit; the slave modport is
//               the surrounding memory / pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_23060042_ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        input  redirect_valid,
        input  redirect_pc,
        input  halt
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        output redirect_valid,
        output redirect_pc,
        output halt
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060042_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060042_ifu_fetch
// Description : Instruction fetch unit. Holds the PC, issues one word fetch
//               at a time to instruction memory, buffers returned words with
//               their PCs in a small FIFO and hands them to decode.
//               Handles execute redirects and a sticky halt from decode.
//               Optional macro YSYX_23060042_IFU_PERF_EN adds the
//               perf_fetch_cnt / perf_stall_cnt counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060042_ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_23060042_ifu_fetch_if.master   bus
`ifdef YSYX_23060042_IFU_PERF_EN
    ,
    output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int               c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_req    = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_drop;
    logic               r_halt_seen;
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_req_valid;
    logic w_hs;
    logic w_outstanding;
    logic w_rsp_acc;
    logic w_flush;
    logic w_redir;
    logic w_push;
    logic w_pop;
    logic w_inst_valid;
    logic w_halt_any;

    // A request is in flight exactly while the FSM waits for its response.
    assign w_outstanding = (r_state == c_st_wait);
    assign w_hs          = w_req_valid & bus.imem_req_ready;
    assign w_rsp_acc     = bus.imem_rsp_valid & w_outstanding;
    assign w_halt_any    = bus.halt | r_halt_seen;
    // Once halted, redirects are ignored; a redirect arriving together with
    // the halt still empties the buffer but does not move the PC.
    assign w_flush       = bus.redirect_valid & ~r_halt_seen;
    assign w_redir       = w_flush & ~bus.halt;
    // A flush discards a response arriving in the same cycle.
    assign w_push        = w_rsp_acc & ~r_drop & ~w_flush;
    assign w_inst_valid  = (r_count != '0);
    assign w_pop         = w_inst_valid & bus.inst_ready & ~w_flush;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst           = r_fifo_data[r_rd_ptr];
    assign bus.inst_pc        = r_fifo_pc[r_rd_ptr];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_req;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: issue -> wait for the single response -> issue again or stop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_req: begin
                if (w_hs) begin
                    w_state_nxt = c_st_wait;
                end else if (w_halt_any) begin
                    w_state_nxt = c_st_halted;
                end
            end
            c_st_wait: begin
                if (w_rsp_acc) begin
                    w_state_nxt = w_halt_any ? c_st_halted : c_st_req;
                end
            end
            c_st_halted: begin
                w_state_nxt = c_st_halted;
            end
            default: begin
                w_state_nxt = c_st_req;
            end
        endcase
    end

    // FSM output: request only when the buffer can absorb the response;
    // held low while reset is asserted.
    always_comb begin
        w_req_valid = 1'b0;
        if (rst_n && (r_state == c_st_req) && (r_count < c_depth)) begin
            w_req_valid = 1'b1;
        end
    end

    // PC, in-flight request PC, drop flag and sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_drop      <= 1'b0;
            r_halt_seen <= 1'b0;
        end else begin
            if (w_redir) begin
                r_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            end else if (w_hs) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_hs) begin
                r_req_pc <= r_pc;
            end
            // The response of a request issued before the redirect is stale.
            if (w_rsp_acc) begin
                r_drop <= 1'b0;
            end else if (w_redir && (w_outstanding || w_hs)) begin
                r_drop <= 1'b1;
            end
            r_halt_seen <= w_halt_any;
        end
    end

    // Instruction buffer: push returned words, pop to decode, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.imem_rsp_data;
                r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef YSYX_23060042_IFU_PERF_EN
    // Performance counters: words delivered into the buffer, and cycles a
    // request sat waiting for memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (w_req_valid && !bus.imem_req_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060042_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060042_ifu_fetch
// Description : Self-checking bench for the fetch unit: a randomised memory
//               and decode environment checked every cycle against a
//               queue-based reference model, plus directed scenarios.
//               Honours YSYX_23060042_IFU_PERF_EN for the counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060042_ifu_fetch;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam int          c_depth    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060042_ifu_fetch_if bus ();

`ifdef YSYX_23060042_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ysyx_23060042_ifu_fetch #(
        .RESET_PC   (c_reset_pc),
        .FIFO_DEPTH (c_depth)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master)
`ifdef YSYX_23060042_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural PC, one in-flight request, drop flag,
    // sticky halt, and the buffered {pc, word} pairs in delivery order.
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_drop;
    bit          m_halt_seen;
    logic [63:0] m_q [$];
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    // Memory model and stimulus knobs.
    bit          mem_busy;
    int          mem_cnt;
    int          k_ready  = 100;
    int          k_iready = 100;
    int          k_redir  = 0;
    int          k_lat    = 1;
    int          k_spur   = 0;
    bit          k_halt_now  = 0;
    bit          k_redir_now = 0;
    logic [31:0] k_redir_pc  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = c_reset_pc;
        m_req_pc    = '0;
        m_out       = 0;
        m_drop      = 0;
        m_halt_seen = 0;
        m_q.delete();
        m_fetch     = '0;
        m_stall     = '0;
        mem_busy    = 0;
        mem_cnt     = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr",   bus.imem_req_addr, c_reset_pc);
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst",       bus.inst, 32'd0);
        chk("rst_inst_pc",    bus.inst_pc, 32'd0);
`ifdef YSYX_23060042_IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    endtask

    // Asserts reset (asynchronously, at the current time), checks the reset
    // outputs, then releases it just after the next rising edge.
    task automatic do_reset();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs at the falling edge,
    // advance the model across the rising edge.
    task automatic tick();
        bit          ready, iready, redir, hlt, rspv, from_mem;
        bit          exp_rv, exp_iv, hs, acc, flush, rd, pop, set_drop;
        logic [31:0] rpc, rdata;
        logic [63:0] head;

        ready    = ($urandom_range(99) < k_ready);
        iready   = ($urandom_range(99) < k_iready);
        redir    = k_redir_now ? 1'b1 : ($urandom_range(99) < k_redir);
        rpc      = k_redir_now ? k_redir_pc : (c_reset_pc + $urandom_range(0, 4095));
        hlt      = k_halt_now;
        rdata    = $urandom;
        from_mem = 0;
        if (mem_busy) begin
            mem_cnt--;
            rspv     = (mem_cnt == 0);
            from_mem = rspv;
        end else begin
            rspv = ($urandom_range(99) < k_spur);
        end

        bus.imem_req_ready = ready;
        bus.inst_ready     = iready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.halt           = hlt;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rdata;

        #4;
        exp_rv = !m_halt_seen && !m_out && (m_q.size() < c_depth);
        exp_iv = (m_q.size() != 0);
        chk("req_valid",  {31'd0, bus.imem_req_valid}, {31'd0, exp_rv});
        chk("req_addr",   bus.imem_req_addr, m_pc);
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_iv});
        if (exp_iv) begin
            head = m_q[0];
            chk("inst",    bus.inst,    head[31:0]);
            chk("inst_pc", bus.inst_pc, head[63:32]);
        end
`ifdef YSYX_23060042_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif

        hs       = exp_rv && ready;
        acc      = rspv && m_out;
        flush    = redir && !m_halt_seen;
        rd       = flush && !hlt;
        pop      = exp_iv && iready && !flush;
        set_drop = rd && ((m_out && !acc) || hs);

        if (exp_rv && !ready) m_stall++;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (!flush && !m_drop) begin
                m_q.push_back({m_req_pc, rdata});
                m_fetch++;
            end
            m_drop = 0;
            m_out  = 0;
        end
        if (from_mem) mem_busy = 0;
        if (flush) m_q.delete();
        if (hs) begin
            m_req_pc = m_pc;
            m_out    = 1;
            m_pc     = m_pc + 32'd4;
            mem_busy = 1;
            mem_cnt  = $urandom_range(1, k_lat);
        end
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        if (set_drop) m_drop = 1;
        if (hlt) m_halt_seen = 1;

        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;

        @(posedge clk);
        #1;
        do_reset();

        // Straight-line fetch: memory always ready, response next cycle.
        k_ready = 100; k_iready = 100; k_lat = 1; k_redir = 0; k_spur = 0;
        run(20);

        // Decode stalls: buffer fills, requests stop, nothing is lost.
        k_iready = 0;
        run(10);
        chk("t2_req_stopped", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("t2_buf_full",    {31'd0, bus.inst_valid},     32'd1);
        k_iready = 100;
        run(10);

        // Redirect while the fetch of 8000_0008 is in flight.
        #2;
        do_reset();
        k_lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out && m_req_pc == 32'h8000_0008) found = 1;
            else tick();
        end
        chk("t3_reach", {31'd0, found}, 32'd1);
        k_redir_now = 1; k_redir_pc = 32'h8000_0100;
        tick();
        k_redir_now = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.inst_valid) begin
                found = 1;
                chk("t3_first_pc", bus.inst_pc, 32'h8000_0100);
            end
        end
        chk("t3_delivered", {31'd0, found}, 32'd1);

        // Redirect coinciding with a response, unaligned target.
        #2;
        do_reset();
        k_lat = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_busy && mem_cnt == 1 && m_req_pc != c_reset_pc) found = 1;
            else tick();
        end
        chk("t4_reach", {31'd0, found}, 32'd1);
        k_redir_now = 1; k_redir_pc = 32'h8000_0203;
        tick();
        k_redir_now = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.imem_req_valid) begin
                found = 1;
                chk("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);
            end else begin
                tick();
            end
        end
        chk("t4_req_seen", {31'd0, found}, 32'd1);
        run(10);

        // Halt with a request in flight: its word still arrives, then silence.
        #2;
        do_reset();
        k_lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out && m_req_pc != c_reset_pc) found = 1;
            else tick();
        end
        chk("t5_reach", {31'd0, found}, 32'd1);
        k_halt_now = 1;
        tick();
        k_halt_now = 0;
        k_redir = 10;
        run(15);
        k_redir = 0;
        chk("t5_no_req",   {31'd0, bus.imem_req_valid}, 32'd0);
        chk("t5_drained",  {31'd0, bus.inst_valid},     32'd0);

        // Memory back-pressure: address held, stall cycles counted; then an
        // asynchronous reset in the middle of the cycle.
        #2;
        do_reset();
        k_ready = 0;
        run(5);
        chk("t6_addr_held", bus.imem_req_addr, c_reset_pc);
`ifdef YSYX_23060042_IFU_PERF_EN
        chk("t6_stall_cnt", perf_stall_cnt, 32'd5);
`endif
        #2;
        do_reset();
        k_ready = 100;
        run(10);

        // PC wrap-around.
        k_redir_now = 1; k_redir_pc = 32'hFFFF_FFF8;
        tick();
        k_redir_now = 0;
        k_lat = 1;
        run(10);

        // Randomised traffic with redirects and spurious responses.
        #2;
        do_reset();
        k_ready = 70; k_iready = 60; k_redir = 5; k_lat = 3; k_spur = 10;
        run(2000);

        // Halt late in random traffic.
        k_halt_now = 1;
        tick();
        k_halt_now = 0;
        run(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
